// File: rtl/systolic_pkg.sv
// Shared types, default sizes and helpers for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      FEED   = 3'd2,
      DRAIN  = 3'd3,
      FIN    = 3'd4
   } sctl_state_e;

   localparam int SIZE_DEF  = 8;
   localparam int CNT_W_DEF = 16;

   // Number of set bits; covers column masks up to 64 columns wide.
   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < 64; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/skew_delay.sv
// Stall-aware 1-bit shift register; tap k is the input delayed by k+1 enabled cycles.
module skew_delay #(
   parameter int DEPTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             d_i,
   output logic [DEPTH-1:0] taps_o
);

   logic [DEPTH-1:0] taps_q;

   // Shift only on enabled cycles so a stall freezes every tap in place
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taps_q <= {DEPTH{1'b0}};
      end else if (en_i) begin
         taps_q <= {taps_q[DEPTH-2:0], d_i};
      end else begin
         taps_q <= taps_q;
      end
   end

   assign taps_o = taps_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the SIZE x SIZE weight-stationary PE array: weight load, activation feed, skewed column enables.
// Defining SYSTOLIC_OPCNT_EN adds the 48-bit op_count output (2*SIZE ops per enabled column per cycle).
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    load_w,
   input  logic [CNT_W-1:0]        num_vec,
   input  logic                    stall,
   output logic                    wt_we,
   output logic [$clog2(SIZE)-1:0] wt_row,
   output logic                    act_rd_en,
   output logic [CNT_W-1:0]        act_rd_addr,
   output logic [SIZE-1:0]         col_en,
   output logic                    out_valid,
   output logic [CNT_W-1:0]        out_idx,
   output logic                    busy,
`ifdef SYSTOLIC_OPCNT_EN
   output logic [47:0]             op_count,
`endif
   output logic                    done
);

   localparam int RW = $clog2(SIZE);

   sctl_state_e      state_q;
   logic [CNT_W-1:0] k_q;
   logic [CNT_W-1:0] addr_q;
   logic [CNT_W-1:0] idx_q;
   logic [RW-1:0]    row_q;
   logic [SIZE:0]    taps_s;
   logic             run_s;
   logic             accept_s;

   assign run_s    = ~stall;
   assign accept_s = (state_q == IDLE) & start;

   // Phase sequencing plus weight-row, activation-address and result-index counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= {CNT_W{1'b0}};
         addr_q  <= {CNT_W{1'b0}};
         idx_q   <= {CNT_W{1'b0}};
         row_q   <= {RW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  k_q    <= num_vec;
                  addr_q <= {CNT_W{1'b0}};
                  row_q  <= {RW{1'b0}};
                  if (load_w) begin
                     state_q <= LOAD_W;
                  end else if (num_vec != {CNT_W{1'b0}}) begin
                     state_q <= FEED;
                  end else begin
                     state_q <= FIN;
                  end
               end
            end
            LOAD_W: begin
               if (run_s) begin
                  if (row_q == RW'(SIZE - 1)) begin
                     row_q   <= {RW{1'b0}};
                     state_q <= (k_q != {CNT_W{1'b0}}) ? FEED : FIN;
                  end else begin
                     row_q <= row_q + RW'(1'b1);
                  end
               end
            end
            FEED: begin
               if (run_s) begin
                  if (addr_q == k_q - CNT_W'(1'b1)) begin
                     addr_q  <= {CNT_W{1'b0}};
                     state_q <= DRAIN;
                  end else begin
                     addr_q <= addr_q + CNT_W'(1'b1);
                  end
               end
            end
            // The last tap can still hold a result; it leaves on this same edge
            DRAIN: begin
               if (run_s && (taps_s[SIZE-1:0] == {SIZE{1'b0}})) begin
                  state_q <= FIN;
               end
            end
            FIN: begin
               if (run_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (accept_s) begin
            idx_q <= {CNT_W{1'b0}};
         end else if (out_valid) begin
            idx_q <= idx_q + CNT_W'(1'b1);
         end else begin
            idx_q <= idx_q;
         end
      end
   end

   skew_delay #(
      .DEPTH (SIZE + 1)
   ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .en_i   (run_s),
      .d_i    (act_rd_en),
      .taps_o (taps_s)
   );

   assign wt_we       = (state_q == LOAD_W) & run_s;
   assign wt_row      = row_q;
   assign act_rd_en   = (state_q == FEED) & run_s;
   assign act_rd_addr = addr_q;
   assign col_en      = taps_s[SIZE-1:0];
   assign out_valid   = taps_s[SIZE] & run_s;
   assign out_idx     = idx_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN) & run_s;

`ifdef SYSTOLIC_OPCNT_EN
   logic [47:0] op_count_q;

   // Operation counter: restarts on each accepted command, holds after completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_q <= 48'd0;
      end else if (accept_s) begin
         op_count_q <= 48'd0;
      end else if (run_s) begin
         op_count_q <= op_count_q + 48'(2 * SIZE) * 48'(popcount(64'(col_en)));
      end else begin
         op_count_q <= op_count_q;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (SIZE=4): directed scenarios plus a randomized run against an index-arithmetic model.
module tb_systolic_ctrl;

   localparam int SIZE  = 4;
   localparam int CNT_W = 16;
   localparam int RW    = $clog2(SIZE);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             load_w = 1'b0;
   logic             stall = 1'b0;
   logic [CNT_W-1:0] num_vec = 16'd0;
   logic             wt_we, act_rd_en, out_valid, busy, done;
   logic [RW-1:0]    wt_row;
   logic [CNT_W-1:0] act_rd_addr, out_idx;
   logic [SIZE-1:0]  col_en;
`ifdef SYSTOLIC_OPCNT_EN
   logic [47:0]      op_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a run is described by unstalled work cycles m_n since acceptance
   bit     m_act = 1'b0;
   int     m_n = 0;
   int     m_L = 0;
   int     m_K = 0;
   longint m_ops = 0;

   systolic_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .load_w(load_w), .num_vec(num_vec),
      .stall(stall), .wt_we(wt_we), .wt_row(wt_row), .act_rd_en(act_rd_en),
      .act_rd_addr(act_rd_addr), .col_en(col_en), .out_valid(out_valid),
      .out_idx(out_idx), .busy(busy),
`ifdef SYSTOLIC_OPCNT_EN
      .op_count(op_count),
`endif
      .done(done));

   always #5 clk = ~clk;

   function automatic int fin_n();
      return (m_K == 0) ? m_L : m_L + m_K + SIZE + 1;
   endfunction

   function automatic logic [SIZE-1:0] exp_col();
      logic [SIZE-1:0] v;
      v = '0;
      if (m_act) begin
         for (int c = 0; c < SIZE; c++) begin
            int t;
            t = m_n - 1 - c - m_L;
            v[c] = (t >= 0) && (t < m_K);
         end
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_act = 1'b0;
         m_ops = 0;
      end else if (!m_act) begin
         if (start) begin
            m_act = 1'b1;
            m_n   = 0;
            m_K   = int'(num_vec);
            m_L   = load_w ? SIZE : 0;
            m_ops = 0;
         end
      end else if (!stall) begin
         m_ops += longint'(2 * SIZE * $countones(exp_col()));
         if (m_n == fin_n()) m_act = 1'b0;
         else m_n++;
      end
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++; if ({wt_we, act_rd_en, out_valid, busy, done} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 00000", {wt_we, act_rd_en, out_valid, busy, done}); end
      n_vec++; if (col_en !== 4'b0) begin n_err++; $display("FAIL reset_col_en: got %b expected 0000", col_en); end
      n_vec++; if ({wt_row, act_rd_addr, out_idx} !== '0) begin n_err++; $display("FAIL reset_counters: got %h expected 0", {wt_row, act_rd_addr, out_idx}); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_load_k3();
      int rows[$], wcyc[$], addrs[$], rcyc[$], idxs[$], vcyc[$];
      int first_c3 = -1, n_done = 0, done_cyc = -1, n_busy = 0;
      start = 1'b1; load_w = 1'b1; num_vec = 16'd3; stall = 1'b0;
      for (int cyc = 0; cyc < 18; cyc++) begin
         @(negedge clk);
         if (wt_we) begin rows.push_back(int'(wt_row)); wcyc.push_back(cyc); end
         if (act_rd_en) begin addrs.push_back(int'(act_rd_addr)); rcyc.push_back(cyc); end
         if (col_en[3] && first_c3 < 0) first_c3 = cyc;
         if (out_valid) begin idxs.push_back(int'(out_idx)); vcyc.push_back(cyc); end
         if (done) begin n_done++; done_cyc = cyc; end
         if (busy) n_busy++;
         tick();
         start = 1'b0;
      end
      n_vec++; if (wcyc.size() !== 4) begin n_err++; $display("FAIL load_wt_count: got %0d expected 4", wcyc.size()); end
      for (int i = 0; i < wcyc.size() && i < 4; i++) begin
         n_vec++; if (wcyc[i] !== i + 1 || rows[i] !== i) begin n_err++; $display("FAIL load_wt_row%0d: got cycle %0d row %0d expected cycle %0d row %0d", i, wcyc[i], rows[i], i + 1, i); end
      end
      n_vec++; if (rcyc.size() !== 3) begin n_err++; $display("FAIL load_rd_count: got %0d expected 3", rcyc.size()); end
      for (int i = 0; i < rcyc.size() && i < 3; i++) begin
         n_vec++; if (rcyc[i] !== i + 5 || addrs[i] !== i) begin n_err++; $display("FAIL load_rd%0d: got cycle %0d addr %0d expected cycle %0d addr %0d", i, rcyc[i], addrs[i], i + 5, i); end
      end
      n_vec++; if (first_c3 !== 9) begin n_err++; $display("FAIL load_col3_first: got %0d expected 9", first_c3); end
      n_vec++; if (vcyc.size() !== 3) begin n_err++; $display("FAIL load_ov_count: got %0d expected 3", vcyc.size()); end
      for (int i = 0; i < vcyc.size() && i < 3; i++) begin
         n_vec++; if (vcyc[i] !== i + 10 || idxs[i] !== i) begin n_err++; $display("FAIL load_ov%0d: got cycle %0d idx %0d expected cycle %0d idx %0d", i, vcyc[i], idxs[i], i + 10, i); end
      end
      n_vec++; if (n_done !== 1 || done_cyc !== 13) begin n_err++; $display("FAIL load_done: got %0d pulses at %0d expected 1 at 13", n_done, done_cyc); end
      n_vec++; if (n_busy !== 13) begin n_err++; $display("FAIL load_busy_len: got %0d expected 13", n_busy); end
   endtask

   task automatic test_k0();
      int n_done = 0, done_cyc = -1, n_rd = 0, n_col = 0;
      start = 1'b1; load_w = 1'b0; num_vec = 16'd0; stall = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (done) begin n_done++; done_cyc = cyc; end
         if (act_rd_en) n_rd++;
         if (col_en != 4'b0) n_col++;
         tick();
         start = 1'b0;
      end
      n_vec++; if (n_done !== 1 || done_cyc !== 1) begin n_err++; $display("FAIL k0_done: got %0d pulses at %0d expected 1 at 1", n_done, done_cyc); end
      n_vec++; if (n_rd !== 0) begin n_err++; $display("FAIL k0_reads: got %0d expected 0", n_rd); end
      n_vec++; if (n_col !== 0) begin n_err++; $display("FAIL k0_col_en: got %0d active cycles expected 0", n_col); end
   endtask

   task automatic test_stall();
      int addrs[$], rcyc[$], idxs[$], vcyc[$];
      int n_done = 0, done_cyc = -1;
      start = 1'b1; load_w = 1'b0; num_vec = 16'd5;
      for (int cyc = 0; cyc < 20; cyc++) begin
         stall = (cyc >= 3 && cyc <= 5);
         @(negedge clk);
         if (act_rd_en) begin addrs.push_back(int'(act_rd_addr)); rcyc.push_back(cyc); end
         if (out_valid) begin idxs.push_back(int'(out_idx)); vcyc.push_back(cyc); end
         if (done) begin n_done++; done_cyc = cyc; end
         if (stall) begin
            n_vec++; if (col_en !== 4'b0011) begin n_err++; $display("FAIL stall_col_hold c%0d: got %b expected 0011", cyc, col_en); end
         end
         tick();
         start = 1'b0;
      end
      stall = 1'b0;
      n_vec++; if (rcyc.size() !== 5) begin n_err++; $display("FAIL stall_rd_count: got %0d expected 5", rcyc.size()); end
      for (int i = 0; i < rcyc.size() && i < 5; i++) begin
         n_vec++; if (addrs[i] !== i || rcyc[i] !== ((i < 2) ? i + 1 : i + 4)) begin n_err++; $display("FAIL stall_rd%0d: got cycle %0d addr %0d expected cycle %0d addr %0d", i, rcyc[i], addrs[i], (i < 2) ? i + 1 : i + 4, i); end
      end
      n_vec++; if (vcyc.size() !== 5) begin n_err++; $display("FAIL stall_ov_count: got %0d expected 5", vcyc.size()); end
      for (int i = 0; i < vcyc.size() && i < 5; i++) begin
         n_vec++; if (idxs[i] !== i || vcyc[i] !== i + 9) begin n_err++; $display("FAIL stall_ov%0d: got cycle %0d idx %0d expected cycle %0d idx %0d", i, vcyc[i], idxs[i], i + 9, i); end
      end
      n_vec++; if (n_done !== 1 || done_cyc !== 14) begin n_err++; $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 14", n_done, done_cyc); end
   endtask

   task automatic test_busy_restart();
      int n_done = 0, done_cyc = -1, n_rd = 0, n_wt = 0, max_addr = -1;
      start = 1'b1; load_w = 1'b1; num_vec = 16'd4; stall = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (done) begin n_done++; done_cyc = cyc; end
         if (act_rd_en) begin n_rd++; if (int'(act_rd_addr) > max_addr) max_addr = int'(act_rd_addr); end
         if (wt_we) n_wt++;
         tick();
         start = (cyc == 2 || cyc == 7);
         if (cyc == 2) begin num_vec = 16'd9; load_w = 1'b0; end
      end
      start = 1'b0; num_vec = 16'd0;
      n_vec++; if (n_done !== 1 || done_cyc !== 14) begin n_err++; $display("FAIL restart_done: got %0d pulses at %0d expected 1 at 14", n_done, done_cyc); end
      n_vec++; if (n_rd !== 4 || max_addr !== 3) begin n_err++; $display("FAIL restart_reads: got %0d reads max %0d expected 4 max 3", n_rd, max_addr); end
      n_vec++; if (n_wt !== 4) begin n_err++; $display("FAIL restart_wt: got %0d expected 4", n_wt); end
   endtask

   task automatic test_reset_drain();
      int n_done = 0, done_cyc = -1, addrs[$], rcyc[$], idxs[$], vcyc[$];
      start = 1'b1; load_w = 1'b0; num_vec = 16'd3; stall = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         tick();
         start = 1'b0;
      end
      @(negedge clk);
      n_vec++; if (busy !== 1'b1 || col_en !== 4'b1110) begin n_err++; $display("FAIL drain_pre_rst: got busy %b col %b expected 1 1110", busy, col_en); end
      rst = 1'b1;
      #1;
      n_vec++; if ({wt_we, act_rd_en, out_valid, busy, done, col_en} !== 9'b0) begin n_err++; $display("FAIL drain_rst_async: got %b expected all 0", {wt_we, act_rd_en, out_valid, busy, done, col_en}); end
      n_vec++; if ({wt_row, act_rd_addr, out_idx} !== '0) begin n_err++; $display("FAIL drain_rst_counters: got %h expected 0", {wt_row, act_rd_addr, out_idx}); end
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         if (done || busy) n_done++;
         tick();
      end
      n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL drain_no_done: got %0d busy/done cycles expected 0", n_done); end
      n_done = 0;
      start = 1'b1; num_vec = 16'd2;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (act_rd_en) begin addrs.push_back(int'(act_rd_addr)); rcyc.push_back(cyc); end
         if (out_valid) begin idxs.push_back(int'(out_idx)); vcyc.push_back(cyc); end
         if (done) begin n_done++; done_cyc = cyc; end
         tick();
         start = 1'b0;
      end
      n_vec++; if (rcyc.size() !== 2 || vcyc.size() !== 2) begin n_err++; $display("FAIL rerun_counts: got %0d reads %0d results expected 2 2", rcyc.size(), vcyc.size()); end
      for (int i = 0; i < rcyc.size() && i < 2 && i < vcyc.size(); i++) begin
         n_vec++; if (addrs[i] !== i || rcyc[i] !== i + 1 || idxs[i] !== i || vcyc[i] !== i + 6) begin n_err++; $display("FAIL rerun_vec%0d: got rd c%0d a%0d ov c%0d i%0d expected rd c%0d a%0d ov c%0d i%0d", i, rcyc[i], addrs[i], vcyc[i], idxs[i], i + 1, i, i + 6, i); end
      end
      n_vec++; if (n_done !== 1 || done_cyc !== 8) begin n_err++; $display("FAIL rerun_done: got %0d pulses at %0d expected 1 at 8", n_done, done_cyc); end
   endtask

`ifdef SYSTOLIC_OPCNT_EN
   task automatic test_opcnt();
      logic [47:0] at_done = 48'd0;
      start = 1'b1; load_w = 1'b0; num_vec = 16'd3; stall = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(negedge clk);
         if (done) at_done = op_count;
         tick();
         start = 1'b0;
      end
      n_vec++; if (at_done !== 48'd96) begin n_err++; $display("FAIL opcnt_at_done: got %0d expected 96", at_done); end
      n_vec++; if (op_count !== 48'd96) begin n_err++; $display("FAIL opcnt_hold: got %0d expected 96", op_count); end
      start = 1'b1; num_vec = 16'd0;
      @(negedge clk);
      tick();
      start = 1'b0;
      @(negedge clk);
      n_vec++; if (op_count !== 48'd0) begin n_err++; $display("FAIL opcnt_clear: got %0d expected 0", op_count); end
      tick();
      tick();
   endtask
`endif

   task automatic test_random();
      bit e_we, e_rd, e_ov, e_done;
      int t_out;
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(0, 4) == 0);
         load_w  = ($urandom_range(0, 1) == 1);
         num_vec = CNT_W'($urandom_range(0, 10));
         stall   = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         e_we   = m_act && !stall && (m_n < m_L);
         e_rd   = m_act && !stall && (m_n >= m_L) && (m_n < m_L + m_K);
         t_out  = m_n - 1 - SIZE - m_L;
         e_ov   = m_act && !stall && (t_out >= 0) && (t_out < m_K);
         e_done = m_act && !stall && (m_n == fin_n());
         n_vec++; if (wt_we !== e_we) begin n_err++; $display("FAIL rnd_wt_we @%0d: got %b expected %b", i, wt_we, e_we); end
         if (e_we) begin n_vec++; if (wt_row !== RW'(m_n)) begin n_err++; $display("FAIL rnd_wt_row @%0d: got %0d expected %0d", i, wt_row, m_n); end end
         n_vec++; if (act_rd_en !== e_rd) begin n_err++; $display("FAIL rnd_rd_en @%0d: got %b expected %b", i, act_rd_en, e_rd); end
         if (e_rd) begin n_vec++; if (act_rd_addr !== CNT_W'(m_n - m_L)) begin n_err++; $display("FAIL rnd_rd_addr @%0d: got %0d expected %0d", i, act_rd_addr, m_n - m_L); end end
         n_vec++; if (col_en !== exp_col()) begin n_err++; $display("FAIL rnd_col_en @%0d: got %b expected %b", i, col_en, exp_col()); end
         n_vec++; if (out_valid !== e_ov) begin n_err++; $display("FAIL rnd_out_valid @%0d: got %b expected %b", i, out_valid, e_ov); end
         if (e_ov) begin n_vec++; if (out_idx !== CNT_W'(t_out)) begin n_err++; $display("FAIL rnd_out_idx @%0d: got %0d expected %0d", i, out_idx, t_out); end end
         n_vec++; if (done !== e_done) begin n_err++; $display("FAIL rnd_done @%0d: got %b expected %b", i, done, e_done); end
         n_vec++; if (busy !== m_act) begin n_err++; $display("FAIL rnd_busy @%0d: got %b expected %b", i, busy, m_act); end
`ifdef SYSTOLIC_OPCNT_EN
         n_vec++; if (op_count !== 48'(m_ops)) begin n_err++; $display("FAIL rnd_op_count @%0d: got %0d expected %0d", i, op_count, m_ops); end
`endif
         tick();
      end
      start = 1'b0; stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_k3();
      test_k0();
      test_stall();
      test_busy_restart();
      test_reset_drain();
`ifdef SYSTOLIC_OPCNT_EN
      test_opcnt();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
